// File: rtl/out_arb_pkg.sv
// Shared definitions for the output FIFO arbiter: state encoding and default sizing.
package out_arb_pkg;

   localparam int unsigned DefWordSize = 16;
   localparam int unsigned DefNReq     = 3;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] GRANT = 2'b01;
   localparam logic [1:0] WRITE = 2'b10;
   localparam logic [1:0] ACK   = 2'b11;

   typedef enum logic [1:0] {
      StIdle  = IDLE,
      StGrant = GRANT,
      StWrite = WRITE,
      StAck   = ACK
   } state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first requester at or after last_grant+1 (mod n_req).
module rr_select #(
   parameter int unsigned n_req = 3,
   parameter int unsigned gw    = 2
) (
   input  logic [n_req-1:0] req,
   input  logic [gw-1:0]    last_grant,
   output logic [gw-1:0]    grant,
   output logic             valid
);

   // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int k = n_req; k >= 1; k--) begin
         int idx;
         idx = (int'(last_grant) + k) % int'(n_req);
         if (req[idx]) begin
            grant = idx[gw-1:0];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_fifo_arbiter.sv
// Round-robin arbiter writing one requester's result/status token pair into two output FIFOs.
// Optional per-requester write counters are enabled with OUT_ARB_COUNT_EN.
module output_fifo_arbiter
   import out_arb_pkg::*;
#(
   parameter int unsigned word_size = DefWordSize,
   parameter int unsigned n_req     = DefNReq
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [n_req-1:0]         req,
   input  logic [n_req*word_size-1:0] result_in,
   input  logic [n_req*word_size-1:0] status_in,
   output logic [n_req-1:0]         ack,
   input  logic                     full_result,
   input  logic                     full_status,
   output logic                     wr_en_result,
   output logic                     wr_en_status,
   output logic [word_size-1:0]     result_out,
   output logic [word_size-1:0]     status_out,
`ifdef OUT_ARB_COUNT_EN
   output logic [n_req*16-1:0]      wr_count,
`endif
   output logic                     busy
);

   localparam int unsigned gw = (n_req > 1) ? $clog2(n_req) : 1;
   localparam logic [gw-1:0] last_init = gw'(n_req - 1);

   state_e        state_q, state_d;
   logic [gw-1:0] grant_q, last_grant_q;
   logic [gw-1:0] sel;
   logic          sel_valid;

   rr_select #(
      .n_req (n_req),
      .gw    (gw)
   ) u_rr_select (
      .req        (req),
      .last_grant (last_grant_q),
      .grant      (sel),
      .valid      (sel_valid)
   );

   // A dropped request wins over a full stall so a vanished requester never blocks the port.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (sel_valid) state_d = StGrant;
         StGrant: begin
            if (!req[grant_q]) begin
               state_d = StIdle;
            end else if (!full_result && !full_status) begin
               state_d = StWrite;
            end
         end
         StWrite: state_d = StAck;
         StAck:   state_d = StIdle;
      endcase
   end

   always_comb begin
      ack          = '0;
      wr_en_result = (state_q == StWrite);
      wr_en_status = (state_q == StWrite);
      busy         = (state_q != StIdle);
      if (state_q == StAck) ack[grant_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= last_init;
         result_out   <= '0;
         status_out   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && sel_valid) begin
            grant_q    <= sel;
            result_out <= result_in[int'(sel)*word_size +: word_size];
            status_out <= status_in[int'(sel)*word_size +: word_size];
         end
         if (state_q == StAck) last_grant_q <= grant_q;
      end
   end

`ifdef OUT_ARB_COUNT_EN
   // 16-bit slices wrap naturally from 16'hFFFF to 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_count <= '0;
      end else if (state_q == StWrite) begin
         wr_count[int'(grant_q)*16 +: 16] <= wr_count[int'(grant_q)*16 +: 16] + 16'd1;
      end
   end
`endif

endmodule
